imem_loader: RTL and testbench

- Instruction memory that sits directly upstream of the PMIPSL0 processor and drives its imemrdata input from the processor's imemaddr.
- Before execution, a byte-serial host interface loads the program, high byte first.
- The processor is held in reset through cpu_reset until loading completes, then released.
- A reload request returns the block to loading without a global reset.

---
 rtl/imem_loader_if.sv | 11 +
 rtl/imem_loader.sv | 66 ++++++
 tb/tb_imem_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-serial host load channel (valid/ready handshake plus last-byte marker)
//   ld_valid - host byte valid      ld_ready - loader can accept a byte
//   ld_byte  - host byte            ld_last  - final byte of the program
interface imem_loader_if;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_byte;
  logic       ld_last;
  modport master (output ld_valid, ld_byte, ld_last, input ld_ready);
  modport slave (input ld_valid, ld_byte, ld_last, output ld_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: instruction memory loaded high-byte-first over a byte channel, holding the CPU in reset until loaded
//   clock, reset (async, active-low) | ld: host load channel (slave) | reload: restart loading from RUN
//   imemaddr/imemrdata: combinational CPU fetch port | cpu_reset, loaded, word_count: status
module imem_loader #(
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  imem_loader_if.slave          ld,
  input  logic                  reload,
  input  logic [15:0]           imemaddr,
  output logic [15:0]           imemrdata,
  output logic                  cpu_reset,
  output logic                  loaded,
  output logic [DEPTH_LOG2:0]   word_count
);
  typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;
  state_t                  state, state_n;
  logic [DEPTH_LOG2-1:0]   ptr, idx;
  logic [7:0]              hold;
  logic [15:0]             mem [0:(1<<DEPTH_LOG2)-1];
  logic                    ready, beat, wr, unused_addr_lsb;
  assign ld.ld_ready = ready;
  assign beat = ld.ld_valid && ready;
  // a word lands on every low-byte beat, and on a high-byte beat that ends the program
  assign wr = beat && (state == LOAD_LO || ld.ld_last);
  always_comb begin
    state_n = state;
    if (state == RUN)
      state_n = reload ? LOAD_HI : RUN;
    else if (beat)
      state_n = (state == LOAD_HI) ? (ld.ld_last ? RUN : LOAD_LO)
                                   : ((ld.ld_last || &ptr) ? RUN : LOAD_HI);
  end
  // status outputs are registered decodes of the next state so they move with the state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= LOAD_HI;
      ptr        <= '0;
      word_count <= '0;
      hold       <= '0;
      ready      <= 1'b1;
      cpu_reset  <= 1'b1;
      loaded     <= 1'b0;
    end else begin
      state     <= state_n;
      ready     <= state_n != RUN;
      cpu_reset <= state_n != RUN;
      loaded    <= state_n == RUN;
      if (beat && state == LOAD_HI) hold <= ld.ld_byte;
      if (state == RUN && reload) begin
        ptr        <= '0;
        word_count <= '0;
      end else if (wr) begin
        ptr        <= ptr + 1'b1;
        word_count <= word_count + 1'b1;
      end
    end
  end
  always_ff @(posedge clock)
    if (wr) mem[ptr] <= (state == LOAD_HI) ? {ld.ld_byte, 8'h00} : {hold, ld.ld_byte};
  // words beyond the current load stay hidden, so stale contents never reach the CPU
  assign idx = imemaddr[DEPTH_LOG2:1];
  assign unused_addr_lsb = imemaddr[0];
  assign imemrdata = (imemaddr[15:DEPTH_LOG2+1] == '0 && {1'b0, idx} < word_count) ? mem[idx] : 16'h0000;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reload = 1'b0;
  logic [15:0] imemaddr = '0;
  logic [15:0] imemrdata;
  logic        cpu_reset, loaded;
  logic [7:0]  word_count;
  int          checks = 0;
  int          errors = 0;
  imem_loader_if ld();
  imem_loader #(.DEPTH_LOG2(7)) dut (
    .clock(clock), .reset(reset), .ld(ld), .reload(reload),
    .imemaddr(imemaddr), .imemrdata(imemrdata),
    .cpu_reset(cpu_reset), .loaded(loaded), .word_count(word_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic last, input int gap);
    @(negedge clock);
    ld.ld_valid = 1'b1;
    ld.ld_byte  = b;
    ld.ld_last  = last;
    @(posedge clock);
    #1;
    ld.ld_valid = 1'b0;
    ld.ld_last  = 1'b0;
    repeat (gap) @(posedge clock);
    #1;
  endtask
  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    imemaddr = addr;
    #1;
    chk(tag, imemrdata, exp);
  endtask
  task automatic do_reload();
    @(negedge clock);
    reload = 1'b1;
    @(posedge clock);
    #1;
    reload = 1'b0;
  endtask
  task automatic basic(input int gap);
    send(8'h61, 1'b0, gap); send(8'h03, 1'b0, gap);
    send(8'h67, 1'b0, gap); send(8'h04, 1'b0, gap);
    send(8'h06, 1'b0, gap);
    chk("cpu_reset_before_last", {15'd0, cpu_reset}, 16'd1);
    send(8'h43, 1'b1, gap);
  endtask
  initial begin
    ld.ld_valid = 1'b0;
    ld.ld_byte  = '0;
    ld.ld_last  = 1'b0;
    #12;
    chk("rst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("rst_ld_ready", {15'd0, ld.ld_ready}, 16'd1);
    chk("rst_loaded", {15'd0, loaded}, 16'd0);
    chk("rst_word_count", {8'd0, word_count}, 16'd0);
    @(negedge clock);
    reset = 1'b1;
    // basic load, with a live read after the first word
    send(8'h61, 1'b0, 0);
    send(8'h03, 1'b0, 0);
    rd(16'd0, 16'h6103, "live_read_word0");
    send(8'h67, 1'b0, 0); send(8'h04, 1'b0, 0); send(8'h06, 1'b0, 0);
    chk("basic_cpu_reset_pre", {15'd0, cpu_reset}, 16'd1);
    send(8'h43, 1'b1, 0);
    chk("basic_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    chk("basic_loaded", {15'd0, loaded}, 16'd1);
    chk("basic_ld_ready", {15'd0, ld.ld_ready}, 16'd0);
    chk("basic_wc", {8'd0, word_count}, 16'd3);
    rd(16'd0, 16'h6103, "basic_a0");
    rd(16'd2, 16'h6704, "basic_a2");
    rd(16'd4, 16'h0643, "basic_a4");
    rd(16'd1, 16'h6103, "basic_a1");
    rd(16'd6, 16'h0000, "basic_a6");
    // bytes offered in RUN are ignored
    send(8'hEE, 1'b0, 2);
    chk("run_ignore_wc", {8'd0, word_count}, 16'd3);
    rd(16'd6, 16'h0000, "run_ignore_a6");
    // reload from RUN
    do_reload();
    chk("reload_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("reload_loaded", {15'd0, loaded}, 16'd0);
    chk("reload_wc", {8'd0, word_count}, 16'd0);
    rd(16'd0, 16'h0000, "reload_a0_hidden");
    send(8'hAB, 1'b0, 0);
    chk("reload_cpu_reset_mid", {15'd0, cpu_reset}, 16'd1);
    send(8'hCD, 1'b1, 0);
    chk("reload_run", {15'd0, loaded}, 16'd1);
    chk("reload_wc1", {8'd0, word_count}, 16'd1);
    rd(16'd0, 16'hABCD, "reload_a0");
    rd(16'd2, 16'h0000, "reload_a2_stale");
    // gaps between bytes
    do_reload();
    basic(3);
    chk("gap_wc", {8'd0, word_count}, 16'd3);
    chk("gap_loaded", {15'd0, loaded}, 16'd1);
    rd(16'd0, 16'h6103, "gap_a0");
    rd(16'd2, 16'h6704, "gap_a2");
    rd(16'd4, 16'h0643, "gap_a4");
    rd(16'd6, 16'h0000, "gap_a6");
    // odd length, with a reload pulse during loading that must be ignored
    do_reload();
    send(8'h12, 1'b0, 0);
    do_reload();
    send(8'h34, 1'b0, 0);
    send(8'h56, 1'b1, 0);
    chk("odd_wc", {8'd0, word_count}, 16'd2);
    chk("odd_loaded", {15'd0, loaded}, 16'd1);
    rd(16'd0, 16'h1234, "odd_a0");
    rd(16'd2, 16'h5600, "odd_a2");
    // full memory without ld_last
    do_reload();
    for (int i = 0; i < 128; i++) begin
      send(i[7:0], 1'b0, 0);
      send(~i[7:0], 1'b0, 0);
    end
    chk("full_loaded", {15'd0, loaded}, 16'd1);
    chk("full_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    chk("full_wc", {8'd0, word_count}, 16'd128);
    rd(16'd0, 16'h00FF, "full_a0");
    rd(16'd254, 16'h7F80, "full_a254");
    rd(16'd256, 16'h0000, "full_a256");
    chk("full_ld_ready", {15'd0, ld.ld_ready}, 16'd0);
    send(8'h99, 1'b1, 2);
    chk("full_extra_wc", {8'd0, word_count}, 16'd128);
    rd(16'd0, 16'h00FF, "full_extra_a0");
    // asynchronous reset in the middle of a load
    do_reload();
    send(8'h11, 1'b0, 0); send(8'h22, 1'b0, 0); send(8'h33, 1'b0, 0);
    rd(16'd0, 16'h1122, "mid_live_a0");
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("mid_rst_loaded", {15'd0, loaded}, 16'd0);
    chk("mid_rst_ld_ready", {15'd0, ld.ld_ready}, 16'd1);
    chk("mid_rst_wc", {8'd0, word_count}, 16'd0);
    rd(16'd0, 16'h0000, "mid_rst_a0");
    @(negedge clock);
    reset = 1'b1;
    send(8'h44, 1'b0, 0);
    send(8'h55, 1'b1, 0);
    chk("fresh_loaded", {15'd0, loaded}, 16'd1);
    chk("fresh_wc", {8'd0, word_count}, 16'd1);
    rd(16'd0, 16'h4455, "fresh_a0");
    rd(16'd2, 16'h0000, "fresh_a2");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
